rom_loader: RTL and testbench

// - Boot-time program loader that sits upstream of the SoC instruction ROM.
// - Consumes a framed byte stream from the UART receiver and writes 32-bit words into the ROM write port.
// - Holds the core in reset until a complete, checksum-valid image is loaded.
// - Replaces $readmemh preloading on silicon/FPGA; the test program then runs and reports via x26/x27 as usual.

---
 rtl/rom_loader_pkg.sv | 31 +++
 rtl/rom_loader_if.sv | 22 ++
 rtl/rom_loader.sv | 149 ++++++++++++++
 tb/tb_rom_loader.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_loader_pkg.sv
// Shared definitions for the boot-time ROM loader: FSM encodings, frame layout and
// checksum helper.
package rom_loader_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StCntLo = 3'd1,
        StCntHi = 3'd2,
        StData  = 3'd3,
        StCsum  = 3'd4,
        StDone  = 3'd5,
        StErr   = 3'd6
    } state_e;

    // Order in which fields arrive on the byte stream.
    typedef enum logic [2:0] {
        FldMagic = 3'd0,
        FldCntLo = 3'd1,
        FldCntHi = 3'd2,
        FldData  = 3'd3,
        FldCsum  = 3'd4
    } frame_field_e;

    localparam logic [7:0]  DEFAULT_MAGIC  = 8'hA5;
    localparam int unsigned BYTES_PER_WORD = 4;

    function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] b);
        return sum + b;
    endfunction

endpackage

// File: rtl/rom_loader_if.sv
// Byte-stream input and ROM write port of the loader, bundled with master
// (environment) and slave (loader) views.
interface rom_loader_if #(
    parameter int unsigned ADDR_W = 12
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              rom_we;
    logic [ADDR_W-1:0] rom_waddr;
    logic [31:0]       rom_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, rom_we, rom_waddr, rom_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, rom_we, rom_waddr, rom_wdata
    );
endinterface

// File: rtl/rom_loader.sv
// Parses MAGIC/count/data/checksum frames from the UART byte stream, writes words
// into the instruction ROM and releases the core only after a verified image.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int unsigned ADDR_W      = 12,
    parameter logic [7:0]  MAGIC       = DEFAULT_MAGIC,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic         clk,
    input  logic         rst_n,
    rom_loader_if.slave  bus,
    output logic         core_rst_n,
    output logic         load_done,
    output logic         load_err
);

    localparam int unsigned TMO_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

    state_e            r_state;
    logic              r_in_ready;
    logic              r_rom_we;
    logic [ADDR_W-1:0] r_rom_waddr;
    logic [31:0]       r_rom_wdata;
    logic              r_core_rst_n;
    logic              r_load_done;
    logic              r_load_err;
    logic [7:0]        r_cnt_lo;
    logic [ADDR_W-1:0] r_word_idx;
    logic [ADDR_W-1:0] r_last_idx;
    logic [1:0]        r_byte_idx;
    logic [23:0]       r_asm;
    logic [7:0]        r_sum;
    logic [TMO_W-1:0]  r_tmo;

    logic        w_accept;
    logic        w_active;
    logic        w_tmo_hit;
    logic [15:0] w_count;

    assign w_accept  = bus.in_valid & r_in_ready;
    assign w_active  = (r_state == StCntLo) || (r_state == StCntHi) ||
                       (r_state == StData)  || (r_state == StCsum);
    assign w_tmo_hit = w_active && !w_accept && (r_tmo == TMO_W'(TIMEOUT_CYC - 1));
    assign w_count   = {bus.in_data, r_cnt_lo};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_in_ready   <= 1'b0;
            r_rom_we     <= 1'b0;
            r_rom_waddr  <= '0;
            r_rom_wdata  <= '0;
            r_core_rst_n <= 1'b0;
            r_load_done  <= 1'b0;
            r_load_err   <= 1'b0;
            r_cnt_lo     <= '0;
            r_word_idx   <= '0;
            r_last_idx   <= '0;
            r_byte_idx   <= '0;
            r_asm        <= '0;
            r_sum        <= '0;
            r_tmo        <= '0;
        end else begin
            r_in_ready <= 1'b1;
            r_rom_we   <= 1'b0;
            if (w_accept || !w_active) begin
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + 1'b1;
            end

            if (w_tmo_hit) begin
                // Partial image stays in the ROM; only the status changes.
                r_state      <= StErr;
                r_load_err   <= 1'b1;
                r_load_done  <= 1'b0;
                r_core_rst_n <= 1'b0;
            end else if (w_accept) begin
                case (r_state)
                    StIdle, StDone, StErr: begin
                        if (bus.in_data == MAGIC) begin
                            r_state      <= StCntLo;
                            r_load_done  <= 1'b0;
                            r_load_err   <= 1'b0;
                            r_core_rst_n <= 1'b0;
                        end
                    end
                    StCntLo: begin
                        r_cnt_lo <= bus.in_data;
                        r_sum    <= bus.in_data;
                        r_state  <= StCntHi;
                    end
                    StCntHi: begin
                        r_sum <= csum_add(r_sum, bus.in_data);
                        if (w_count == '0) begin
                            r_state <= StCsum;
                        end else if ({1'b0, w_count} > MAX_WORDS) begin
                            r_state    <= StErr;
                            r_load_err <= 1'b1;
                        end else begin
                            r_state    <= StData;
                            r_word_idx <= '0;
                            r_byte_idx <= '0;
                            r_last_idx <= ADDR_W'(w_count - 16'd1);
                        end
                    end
                    StData: begin
                        r_sum      <= csum_add(r_sum, bus.in_data);
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (r_byte_idx == 2'(BYTES_PER_WORD - 1)) begin
                            r_rom_we    <= 1'b1;
                            r_rom_waddr <= r_word_idx;
                            r_rom_wdata <= {bus.in_data, r_asm};
                            r_word_idx  <= r_word_idx + 1'b1;
                            if (r_word_idx == r_last_idx) begin
                                r_state <= StCsum;
                            end
                        end else begin
                            // Bytes enter at the top so byte 0 ends up in bits [7:0].
                            r_asm <= {bus.in_data, r_asm[23:8]};
                        end
                    end
                    StCsum: begin
                        if (bus.in_data == r_sum) begin
                            r_state      <= StDone;
                            r_load_done  <= 1'b1;
                            r_core_rst_n <= 1'b1;
                        end else begin
                            r_state    <= StErr;
                            r_load_err <= 1'b1;
                        end
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.rom_we    = r_rom_we;
    assign bus.rom_waddr = r_rom_waddr;
    assign bus.rom_wdata = r_rom_wdata;
    assign core_rst_n    = r_core_rst_n;
    assign load_done     = r_load_done;
    assign load_err      = r_load_err;

endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader: directed frames plus randomized frames checked
// against a frame-level reference model.
module tb_rom_loader;
    import rom_loader_pkg::*;

    localparam int unsigned AW  = 4;
    localparam int unsigned TMO = 100;

    typedef logic [7:0] byteq_t[$];

    logic clk;
    logic rst_n;
    logic core_rst_n;
    logic load_done;
    logic load_err;

    int n_checks;
    int n_pass;

    logic [AW-1:0] got_addr[$];
    logic [31:0]   got_data[$];

    rom_loader_if #(.ADDR_W(AW)) bus ();

    rom_loader #(
        .ADDR_W     (AW),
        .MAGIC      (8'hA5),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .core_rst_n(core_rst_n),
        .load_done (load_done),
        .load_err  (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every ROM write strobe is visible at exactly one falling edge.
    always @(negedge clk) begin
        if (bus.rom_we === 1'b1) begin
            got_addr.push_back(bus.rom_waddr);
            got_data.push_back(bus.rom_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; the byte is taken on the following rising edge.
    task automatic send_byte(input logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    function automatic byteq_t make_frame(input int unsigned n, input bit bad);
        byteq_t      q;
        logic [7:0]  b;
        logic [15:0] n16;
        int unsigned s;
        n16 = 16'(n);
        q = {};
        q.push_back(8'hA5);
        q.push_back(n16[7:0]);
        q.push_back(n16[15:8]);
        if (n > (1 << AW)) return q;
        s = int'(n16[7:0]) + int'(n16[15:8]);
        for (int i = 0; i < int'(4 * n); i++) begin
            b = 8'($urandom_range(0, 255));
            q.push_back(b);
            s += int'(b);
        end
        if (bad) s += $urandom_range(1, 255);
        q.push_back(8'(s % 256));
        return q;
    endfunction

    // Sends one frame and checks status, then writes, against the frame-level rules.
    task automatic run_frame(input string tag, input byteq_t fr, input bit gaps);
        int unsigned n;
        int unsigned s;
        bit          ovf;
        bit          ok;
        logic [31:0] w;
        logic [7:0]  b;
        got_addr.delete();
        got_data.delete();
        foreach (fr[i]) begin
            send_byte(fr[i]);
            if (gaps && (i != fr.size() - 1)) idle($urandom_range(0, 2));
        end
        n   = int'(fr[1]) + 256 * int'(fr[2]);
        ovf = n > (1 << AW);
        ok  = 1'b0;
        if (!ovf) begin
            s = int'(fr[1]) + int'(fr[2]);
            for (int i = 0; i < int'(4 * n); i++) s += int'(fr[3 + i]);
            ok = (s % 256) == int'(fr[3 + 4 * n]);
        end
        check({tag, ".done"}, 32'(load_done), 32'(ok));
        check({tag, ".err"}, 32'(load_err), 32'(!ok));
        check({tag, ".core_rst_n"}, 32'(core_rst_n), 32'(ok));
        if (gaps) begin
            // Non-MAGIC bytes after the frame must be ignored.
            repeat ($urandom_range(0, 2)) begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'hA5) b = 8'h00;
                send_byte(b);
            end
            check({tag, ".stray_done"}, 32'(load_done), 32'(ok));
            check({tag, ".stray_err"}, 32'(load_err), 32'(!ok));
        end
        idle(2);
        check({tag, ".nwr"}, 32'(got_addr.size()), ovf ? 32'd0 : 32'(n));
        for (int k = 0; k < got_addr.size() && k < int'(n); k++) begin
            w = {fr[6 + 4 * k], fr[5 + 4 * k], fr[4 + 4 * k], fr[3 + 4 * k]};
            check($sformatf("%s.addr%0d", tag, k), 32'(got_addr[k]), 32'(k));
            check($sformatf("%s.data%0d", tag, k), got_data[k], w);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        byteq_t      fr;
        int unsigned n;
        bit          bad;
        n_checks     = 0;
        n_pass       = 0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        rst_n        = 1'b1;
        #2 rst_n = 1'b0;

        // Reset held while the UART side keeps offering MAGIC.
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = (i % 2) == 0;
            bus.in_data  = 8'hA5;
            @(negedge clk);
            check("rst.in_ready", 32'(bus.in_ready), 32'd0);
            check("rst.core_rst_n", 32'(core_rst_n), 32'd0);
            check("rst.rom_we", 32'(bus.rom_we), 32'd0);
        end
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst.nwr", 32'(got_addr.size()), 32'd0);
        check("post_rst.in_ready", 32'(bus.in_ready), 32'd1);
        check("post_rst.done", 32'(load_done), 32'd0);
        check("post_rst.err", 32'(load_err), 32'd0);

        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        idle(3);
        check("stray.nwr", 32'(got_addr.size()), 32'd0);
        check("stray.done", 32'(load_done), 32'd0);
        check("stray.err", 32'(load_err), 32'd0);

        fr = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
               8'h93, 8'h00, 8'h10, 8'h00, 8'hB8};
        run_frame("good", fr, 1'b0);
        check("good.word0", got_data.size() > 0 ? got_data[0] : 32'hDEADBEEF, 32'h0000_0013);
        check("good.word1", got_data.size() > 1 ? got_data[1] : 32'hDEADBEEF, 32'h0010_0093);
        fr[11] = 8'hBA;
        run_frame("badcs", fr, 1'b0);
        fr[11] = 8'hB8;
        run_frame("good2", fr, 1'b0);

        run_frame("ovf17", make_frame(17, 1'b0), 1'b0);
        run_frame("max16", make_frame(16, 1'b0), 1'b0);

        got_addr.delete();
        got_data.delete();
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h13);
        idle(TMO - 1);
        check("tmo.err_early", 32'(load_err), 32'd0);
        idle(1);
        check("tmo.err", 32'(load_err), 32'd1);
        check("tmo.core_rst_n", 32'(core_rst_n), 32'd0);
        send_byte(8'h00);
        send_byte(8'h22);
        idle(2);
        check("tmo.err_hold", 32'(load_err), 32'd1);
        check("tmo.nwr", 32'(got_addr.size()), 32'd0);

        fr = '{8'hA5, 8'h00, 8'h00, 8'h00};
        run_frame("zero", fr, 1'b0);
        send_byte(8'hA5);
        check("reload.core_rst_n", 32'(core_rst_n), 32'd0);
        check("reload.done", 32'(load_done), 32'd0);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h13);
        send_byte(8'h00);
        #2 rst_n = 1'b0;
        #1;
        check("arst.in_ready", 32'(bus.in_ready), 32'd0);
        check("arst.rom_we", 32'(bus.rom_we), 32'd0);
        check("arst.waddr", 32'(bus.rom_waddr), 32'd0);
        check("arst.wdata", bus.rom_wdata, 32'd0);
        check("arst.core_rst_n", 32'(core_rst_n), 32'd0);
        check("arst.done", 32'(load_done), 32'd0);
        check("arst.err", 32'(load_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("arst.in_ready_rel", 32'(bus.in_ready), 32'd1);

        for (int t = 0; t < 30; t++) begin
            n   = $urandom_range(0, 17);
            bad = $urandom_range(0, 3) == 0;
            if ($urandom_range(0, 7) == 0) n += 256 * $urandom_range(1, 255);
            run_frame($sformatf("rnd%0d", t), make_frame(n, bad), 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
